matmul_seq_engine: RTL and testbench
====================================

Name: matmul_seq_engine

Overview:
- Sequential successor to the matmul calc stage. Fully parametrised in DATA_WIDTH/BUS_WIDTH, so MAX_DIM = BUS_WIDTH/DATA_WIDTH.
- Loads A, B and optional C-bias rows over a valid/ready operand bus.
- Computes C = A·B (+C) with one signed MAC per cycle.
- Writes only the valid (n+1)×(m+1) result elements to the scratchpad through a back-pressured write port, then raises done and per-element overflow flags.
- Sits between the control/register block and the scratchpad.

Parameters:
- DATA_WIDTH, 8, signed operand element width.
- BUS_WIDTH, 32, operand bus and result element width. Must be a multiple of DATA_WIDTH, with MAX_DIM ≤ 8.
- ADDR_WIDTH, 32, scratchpad write address width.
- MAX_DIM (localparam), BUS_WIDTH/DATA_WIDTH, maximum matrix dimension.
- DW (localparam), $clog2(MAX_DIM), dimension field width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  start request; sampled only in IDLE.
- mode_i  in  1  1 = load C bias and add it; sampled with start.
- n_dim_i, k_dim_i, m_dim_i  in  DW each  dimension minus 1 (A is N×K, B is K×M); sampled with start.
- op_data_i  in  BUS_WIDTH  operand beat.
- op_valid_i  in  1  operand beat valid.
- op_ready_o  out  1  engine accepts operand beat.
- wr_addr_o  out  ADDR_WIDTH  scratchpad address.
- wr_data_o  out  BUS_WIDTH  result element.
- wr_valid_o  out  1  write request.
- wr_ready_i  in  1  scratchpad accepts write.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle completion pulse.
- flags_o  out  BUS_WIDTH  overflow flag per element; bit i*MAX_DIM+j, upper bits 0.

Behaviour:
- Reset: all outputs 0; state IDLE; operand, result and flag registers cleared.
- FSM: IDLE → LOAD_A → LOAD_B → (LOAD_C if mode) → MAC → WRITE → DONE → IDLE.
- IDLE: start_i=1 latches dims/mode, clears flags_o, sets busy_o next cycle. start_i in any other state is ignored.
- Handshake: a beat transfers when op_valid_i && op_ready_o. op_ready_o=1 only in LOAD_*.
- LOAD_A: n+1 beats, row r = beat r. Element c is op_data_i[(c+1)*DATA_WIDTH-1 -: DATA_WIDTH]; columns >k ignored.
- LOAD_B: k+1 beats, row r; columns >m ignored.
- LOAD_C: (n+1)(m+1) beats, row-major, one signed BUS_WIDTH element per beat. When mode=0, the bias is treated as 0 and LOAD_C is skipped.
- Idle cycles inside a load phase are allowed without limit.
- MAC: loop i=0..n, j=0..m, k=0..k.
  - Accumulator is BUS_WIDTH+1 bits signed; initialised to the bias (or 0) at k=0, then += A[i][k]·B[k][j], sign-extended.
  - After the last k, store the result truncated to BUS_WIDTH. Set flag[i*MAX_DIM+j] if the value is outside the signed BUS_WIDTH range.
  - Duration is exactly (n+1)(m+1)(k+1) cycles.
- WRITE: element e walks row-major over valid (i,j).
  - wr_addr_o[4:0]=OPERAND_C (5'b10000); wr_addr_o[5+2DW-1:5]=i*MAX_DIM+j; other bits 0.
  - wr_valid_o=1. Address and data are held stable while !wr_ready_i.
  - Advance on accept. wr_valid_o never deasserts before accept.
- DONE: after the last accept, done_o=1 for one cycle and busy_o falls the same cycle. flags_o holds until the next accepted start.
- Boundaries:
  - All dims 0 (1×1): 1 MAC cycle, 1 write.
  - Max dims: MAX_DIM³ MAC cycles.
  - Back-to-back start is accepted on the cycle after DONE.
  - Reset mid-operation returns to IDLE immediately; no partial write stays asserted.

Optional Feature:
- MATMUL_SAT_EN defined: out-of-range results saturate to 0x7FF…F or 0x800…0; the flag is still set.
- MATMUL_SAT_EN undefined: results wrap (two's-complement truncation).

Decomposition:
- matmul_pkg holds OPERAND_A/B/C address codes (5'b00100/01000/10000), FSM state encodings and the MAX_DIM derivation.
- One sub-module, matmul_mac_unit: signed DATA_WIDTH×DATA_WIDTH multiply, BUS_WIDTH+1 accumulate, init/load control, out-of-range detect and optional saturation.
- The FSM and the operand/result register files stay in the top.

Test Plan:
- 2×2 test (n=k=m=1, mode=0): A=[[1,2],[3,4]], B=[[5,6],[7,8]].
  - Writes 19,22,43,50 at indices 0,1,4,5 with addr[4:0]=10000.
  - 8 MAC cycles; done_o a single pulse; flags_o=0.
- 4×4 test with bias (mode=1): A=identity, B[r][c]=r*4+c, C all 100 → 16 writes of 100+r*4+c.
- Back-pressure: wr_ready_i low for 3 cycles on element 1.
  - wr_addr_o and wr_data_o stay constant; no element is duplicated or skipped.
  - op_valid_i gaps during load do not change the result.
- Overflow with 1×1, mode=1: C=0x7FFFFFFF, A=1, B=1.
  - Without the macro: writes 0x80000000 and flags_o=1.
  - With MATMUL_SAT_EN: writes 0x7FFFFFFF and flags_o=1.
- start_i pulsed during MAC is ignored, and the result is unchanged. rst_ni asserted mid-WRITE drives all outputs to 0 immediately, and IDLE accepts a new start.

Source files
------------

// File: rtl/matmul_pkg.sv
// matmul_pkg: address codes, FSM encoding and dimension helper for the
// sequential matmul engine.
package matmul_pkg;

    localparam logic [4:0] OPERAND_A = 5'b00100;
    localparam logic [4:0] OPERAND_B = 5'b01000;
    localparam logic [4:0] OPERAND_C = 5'b10000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_LOAD_C = 3'd3,
        ST_MAC    = 3'd4,
        ST_WRITE  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    function automatic int max_dim(input int bus_w, input int data_w);
        return bus_w / data_w;
    endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// matmul_mac_unit: signed multiply-accumulate with overflow detect.
// MATMUL_SAT_EN selects saturating instead of wrapping results.
module matmul_mac_unit
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en,
    input  logic                         init,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [BUS_WIDTH-1:0]  bias,
    output logic signed [BUS_WIDTH-1:0]  result,
    output logic                         ovf
);

    localparam int ACCW = BUS_WIDTH + 1;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACCW-1:0]         acc_q;
    logic signed [ACCW-1:0]         base;
    logic signed [ACCW-1:0]         sum;

    assign prod = a * b;
    assign base = init ? ACCW'(bias) : acc_q;
    assign sum  = base + ACCW'(prod);
    // The extra guard bit disagrees with the sign bit only when out of range
    assign ovf  = sum[ACCW-1] != sum[ACCW-2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum;
        end
    end

`ifdef MATMUL_SAT_EN
    always_comb begin
        result = sum[BUS_WIDTH-1:0];
        if (ovf) begin
            result = sum[ACCW-1] ? {1'b1, {(BUS_WIDTH-1){1'b0}}}
                                 : {1'b0, {(BUS_WIDTH-1){1'b1}}};
        end
    end
`else
    assign result = sum[BUS_WIDTH-1:0];
`endif

endmodule

// File: rtl/matmul_seq_engine.sv
// matmul_seq_engine: loads A/B/(C), runs one MAC per cycle, writes results.
// Define MATMUL_SAT_EN for saturating results instead of wrapping.
module matmul_seq_engine
    import matmul_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int BUS_WIDTH  = 32,
    parameter  int ADDR_WIDTH = 32,
    localparam int MAX_DIM    = max_dim(BUS_WIDTH, DATA_WIDTH),
    localparam int DW         = $clog2(MAX_DIM)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [DW-1:0]         n_dim_i,
    input  logic [DW-1:0]         k_dim_i,
    input  logic [DW-1:0]         m_dim_i,
    input  logic [BUS_WIDTH-1:0]  op_data_i,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [BUS_WIDTH-1:0]  wr_data_o,
    output logic                  wr_valid_o,
    input  logic                  wr_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [BUS_WIDTH-1:0]  flags_o
);

    localparam int IW  = 2 * DW;
    localparam int NEL = MAX_DIM * MAX_DIM;

    state_t state_q, state_d;

    logic          mode_q;
    logic [DW-1:0] nd_q, kd_q, md_q;
    logic [DW-1:0] i_q, j_q, k_q;

    logic signed [DATA_WIDTH-1:0] a_mem [MAX_DIM][MAX_DIM];
    logic signed [DATA_WIDTH-1:0] b_mem [MAX_DIM][MAX_DIM];
    logic signed [BUS_WIDTH-1:0]  c_mem [NEL];
    logic [BUS_WIDTH-1:0]         r_mem [NEL];
    logic [BUS_WIDTH-1:0]         flags_q;

    logic                        beat, i_last, j_last, k_last;
    logic [IW-1:0]               idx;
    logic signed [BUS_WIDTH-1:0] bias, mac_res;
    logic                        mac_ovf, mac_en;

    assign beat   = op_valid_i && op_ready_o;
    assign i_last = i_q == nd_q;
    assign j_last = j_q == md_q;
    assign k_last = k_q == kd_q;
    assign idx    = IW'(i_q) * IW'(MAX_DIM) + IW'(j_q);
    assign bias   = mode_q ? c_mem[idx] : '0;
    assign mac_en = state_q == ST_MAC;

    matmul_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH)
    ) u_mac (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (mac_en),
        .init   (k_q == '0),
        .a      (a_mem[i_q][k_q]),
        .b      (b_mem[k_q][j_q]),
        .bias   (bias),
        .result (mac_res),
        .ovf    (mac_ovf)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_LOAD_A;
            ST_LOAD_A: if (beat && i_last) state_d = ST_LOAD_B;
            ST_LOAD_B: begin
                if (beat && k_last) begin
                    state_d = mode_q ? ST_LOAD_C : ST_MAC;
                end
            end
            ST_LOAD_C: begin
                if (beat && i_last && j_last) state_d = ST_MAC;
            end
            ST_MAC: begin
                if (k_last && j_last && i_last) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_ready_i && i_last && j_last) state_d = ST_DONE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q  <= 1'b0;
            nd_q    <= '0;
            kd_q    <= '0;
            md_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            flags_q <= '0;
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
            for (int e = 0; e < NEL; e++) begin
                c_mem[e] <= '0;
                r_mem[e] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_q  <= mode_i;
                        nd_q    <= n_dim_i;
                        kd_q    <= k_dim_i;
                        md_q    <= m_dim_i;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        flags_q <= '0;
                    end
                end
                ST_LOAD_A: begin
                    if (beat) begin
                        for (int c = 0; c < MAX_DIM; c++) begin
                            a_mem[i_q][c] <=
                                op_data_i[c*DATA_WIDTH +: DATA_WIDTH];
                        end
                        i_q <= i_last ? '0 : i_q + 1'b1;
                    end
                end
                ST_LOAD_B: begin
                    if (beat) begin
                        for (int c = 0; c < MAX_DIM; c++) begin
                            b_mem[k_q][c] <=
                                op_data_i[c*DATA_WIDTH +: DATA_WIDTH];
                        end
                        k_q <= k_last ? '0 : k_q + 1'b1;
                    end
                end
                ST_LOAD_C: begin
                    if (beat) begin
                        c_mem[idx] <= op_data_i;
                        j_q <= j_last ? '0 : j_q + 1'b1;
                        if (j_last) i_q <= i_last ? '0 : i_q + 1'b1;
                    end
                end
                ST_MAC: begin
                    k_q <= k_last ? '0 : k_q + 1'b1;
                    if (k_last) begin
                        r_mem[idx] <= mac_res;
                        if (mac_ovf) begin
                            flags_q <= flags_q | (BUS_WIDTH'(1) << idx);
                        end
                        j_q <= j_last ? '0 : j_q + 1'b1;
                        if (j_last) i_q <= i_last ? '0 : i_q + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (wr_ready_i) begin
                        j_q <= j_last ? '0 : j_q + 1'b1;
                        if (j_last) i_q <= i_last ? '0 : i_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from state so a reset clears them at once
    assign op_ready_o = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B)
                     || (state_q == ST_LOAD_C);
    assign busy_o     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o     = state_q == ST_DONE;
    assign wr_valid_o = state_q == ST_WRITE;
    assign wr_data_o  = wr_valid_o ? r_mem[idx] : '0;
    assign flags_o    = flags_q;

    always_comb begin
        wr_addr_o = '0;
        if (wr_valid_o) begin
            wr_addr_o[4:0]     = OPERAND_C;
            wr_addr_o[5 +: IW] = idx;
        end
    end

endmodule

// File: tb/tb_matmul_seq_engine.sv
// tb_matmul_seq_engine: directed and random runs against an arithmetic
// reference model of C = A*B (+C).
`timescale 1ns/1ps
module tb_matmul_seq_engine;

    localparam int DWID = 8;
    localparam int BW   = 32;
    localparam int AW   = 32;
    localparam int MD   = BW / DWID;
    localparam int DIMW = $clog2(MD);
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            start_i = 1'b0;
    logic            mode_i = 1'b0;
    logic [DIMW-1:0] n_dim_i = '0;
    logic [DIMW-1:0] k_dim_i = '0;
    logic [DIMW-1:0] m_dim_i = '0;
    logic [BW-1:0]   op_data_i = '0;
    logic            op_valid_i = 1'b0;
    logic            op_ready_o;
    logic [AW-1:0]   wr_addr_o;
    logic [BW-1:0]   wr_data_o;
    logic            wr_valid_o;
    logic            wr_ready_i = 1'b0;
    logic            busy_o;
    logic            done_o;
    logic [BW-1:0]   flags_o;

    matmul_seq_engine #(
        .DATA_WIDTH (DWID),
        .BUS_WIDTH  (BW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .n_dim_i    (n_dim_i),
        .k_dim_i    (k_dim_i),
        .m_dim_i    (m_dim_i),
        .op_data_i  (op_data_i),
        .op_valid_i (op_valid_i),
        .op_ready_o (op_ready_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .wr_valid_o (wr_valid_o),
        .wr_ready_i (wr_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .flags_o    (flags_o)
    );

    always #5 clk_i = ~clk_i;

    int          vectors = 0;
    int          errs = 0;
    int          a_m [MD][MD];
    int          b_m [MD][MD];
    longint      c_m [MD*MD];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_dat [$];
    logic [31:0] exp_flags;
    int          gap_max = 0;
    int          bp_mode = 0;
    bit          start_in_mac = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_mats();
        for (int r = 0; r < MD; r++) begin
            for (int c = 0; c < MD; c++) begin
                a_m[r][c] = int'($signed(8'($urandom)));
                b_m[r][c] = int'($signed(8'($urandom)));
            end
        end
        for (int e = 0; e < MD*MD; e++) c_m[e] = longint'($signed($urandom));
    endtask

    task automatic model(input int n, input int k, input int m, input bit md);
        longint s;
        exp_addr.delete();
        exp_dat.delete();
        exp_flags = '0;
        for (int i = 0; i <= n; i++) begin
            for (int j = 0; j <= m; j++) begin
                s = md ? c_m[i*MD+j] : 64'sd0;
                for (int kk = 0; kk <= k; kk++) s += a_m[i][kk] * b_m[kk][j];
                if (s > SMAX || s < SMIN) exp_flags[i*MD+j] = 1'b1;
`ifdef MATMUL_SAT_EN
                if (s > SMAX) s = SMAX;
                if (s < SMIN) s = SMIN;
`endif
                exp_addr.push_back(32'((i*MD + j) * 32 + 16));
                exp_dat.push_back(s[31:0]);
            end
        end
    endtask

    task automatic do_start(input int n, input int k, input int m,
                            input bit md, input bit wait_first);
        if (wait_first) @(negedge clk_i);
        start_i = 1'b1;
        mode_i  = md;
        n_dim_i = DIMW'(n);
        k_dim_i = DIMW'(k);
        m_dim_i = DIMW'(m);
        @(negedge clk_i);
        start_i = 1'b0;
        mode_i  = 1'($urandom);
        n_dim_i = DIMW'($urandom);
        k_dim_i = DIMW'($urandom);
        m_dim_i = DIMW'($urandom);
        check("busy_after_start", busy_o, 1);
        check("flags_cleared", flags_o, 0);
    endtask

    task automatic feed_beat(input logic [BW-1:0] d);
        int t = 0;
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk_i);
        op_valid_i = 1'b1;
        op_data_i  = d;
        while (!op_ready_o && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 100) check("op_ready_timeout", 0, 1);
        @(negedge clk_i);
        op_valid_i = 1'b0;
        op_data_i  = $urandom;
    endtask

    task automatic feed_all(input int n, input int k, input int m,
                            input bit md);
        logic [BW-1:0] d;
        for (int r = 0; r <= n; r++) begin
            for (int c = 0; c < MD; c++) d[c*DWID +: DWID] = a_m[r][c][7:0];
            feed_beat(d);
        end
        for (int r = 0; r <= k; r++) begin
            for (int c = 0; c < MD; c++) d[c*DWID +: DWID] = b_m[r][c][7:0];
            feed_beat(d);
        end
        if (md) begin
            for (int i = 0; i <= n; i++) begin
                for (int j = 0; j <= m; j++) feed_beat(c_m[i*MD+j][31:0]);
            end
        end
    endtask

    task automatic collect(input int n, input int k, input int m);
        int mac_cnt = 0;
        int e = 0;
        int hold = 0;
        int t = 0;
        int total = (n+1) * (m+1);
        while (e < total && t < 3000) begin
            t++;
            start_i = 1'b0;
            if (wr_valid_o) begin
                check("wr_addr", wr_addr_o, exp_addr[e]);
                check("wr_data", wr_data_o, exp_dat[e]);
                case (bp_mode)
                    0: wr_ready_i = 1'b1;
                    1: wr_ready_i = 1'($urandom_range(0, 1));
                    default: begin
                        wr_ready_i = !(e == 1 && hold < 3);
                        if (!wr_ready_i) hold++;
                    end
                endcase
                if (wr_ready_i) e++;
            end else begin
                wr_ready_i = 1'($urandom_range(0, 1));
                if (busy_o && e == 0) mac_cnt++;
                if (start_in_mac && mac_cnt == 1) begin
                    start_i = 1'b1;
                    mode_i  = 1'b1;
                    n_dim_i = '0;
                    k_dim_i = '0;
                    m_dim_i = '0;
                end
            end
            @(negedge clk_i);
        end
        start_i    = 1'b0;
        wr_ready_i = 1'b0;
        check("writes_done", e, total);
        check("mac_cycles", mac_cnt, (n+1)*(m+1)*(k+1));
        check("done_pulse", done_o, 1);
        check("busy_at_done", busy_o, 0);
        check("flags", flags_o, exp_flags);
        @(negedge clk_i);
        check("done_single", done_o, 0);
        check("flags_hold", flags_o, exp_flags);
    endtask

    task automatic run_op(input int n, input int k, input int m,
                          input bit md, input bit wait_first);
        model(n, k, m, md);
        do_start(n, k, m, md, wait_first);
        feed_all(n, k, m, md);
        collect(n, k, m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, m, t;
        bit md;
        #12;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ready", op_ready_o, 0);
        check("rst_wvalid", wr_valid_o, 0);
        check("rst_waddr", wr_addr_o, 0);
        check("rst_wdata", wr_data_o, 0);
        check("rst_flags", flags_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // 2x2, no bias
        rand_mats();
        a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
        b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
        run_op(1, 1, 1, 0, 1);

        // 4x4 identity * ramp + 100 with gaps and a stall on element 1
        for (int r = 0; r < MD; r++) begin
            for (int c = 0; c < MD; c++) begin
                a_m[r][c] = (r == c) ? 1 : 0;
                b_m[r][c] = r*4 + c;
                c_m[r*MD+c] = 100;
            end
        end
        gap_max = 3;
        bp_mode = 2;
        run_op(3, 3, 3, 1, 1);

        // 1x1 overflow through the bias
        gap_max = 0;
        bp_mode = 0;
        rand_mats();
        a_m[0][0] = 1;
        b_m[0][0] = 1;
        c_m[0] = 64'sd2147483647;
        run_op(0, 0, 0, 1, 1);

        // start pulsed during MAC is ignored
        rand_mats();
        start_in_mac = 1;
        bp_mode = 1;
        run_op(2, 3, 2, 1, 1);
        start_in_mac = 0;

        // reset while a write is stalled
        rand_mats();
        model(1, 1, 1, 0);
        do_start(1, 1, 1, 0, 1);
        feed_all(1, 1, 1, 0);
        wr_ready_i = 1'b0;
        t = 0;
        while (!wr_valid_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        check("wvalid_before_rst", wr_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_wvalid", wr_valid_o, 0);
        check("mid_rst_waddr", wr_addr_o, 0);
        check("mid_rst_wdata", wr_data_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_ready", op_ready_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        rand_mats();
        run_op(1, 2, 0, 0, 1);

        // random operations, back-to-back starts
        gap_max = 2;
        for (int r = 0; r < 20; r++) begin
            n  = $urandom_range(0, MD-1);
            k  = $urandom_range(0, MD-1);
            m  = $urandom_range(0, MD-1);
            md = 1'($urandom);
            bp_mode = $urandom_range(0, 1);
            rand_mats();
            run_op(n, k, m, md, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
